// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_gen
// Description : Recovers pixel/line position from incoming active-low syncs and
//               emits an RGB444 test pattern with the syncs delayed to match.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pattern_gen #(
    parameter int H_VIDEO   = 640,
    parameter int H_OFFSET  = 48,
    parameter int V_VIDEO   = 480,
    parameter int V_OFFSET  = 31,
    parameter int BAR_WIDTH = 80
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_pix_ce,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [1:0]  i_mode,
    input  logic [11:0] i_solid_rgb,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic [3:0]  o_red,
    output logic [3:0]  o_green,
    output logic [3:0]  o_blue,
    output logic        o_de,
    output logic        o_locked
);

    localparam int                 c_BPX_W    = $clog2(BAR_WIDTH);
    localparam logic [10:0]        c_H_START  = 11'(H_OFFSET);
    localparam logic [10:0]        c_H_END    = 11'(H_OFFSET + H_VIDEO);
    localparam logic [9:0]         c_V_START  = 10'(V_OFFSET);
    localparam logic [9:0]         c_V_END    = 10'(V_OFFSET + V_VIDEO);
    localparam logic [c_BPX_W-1:0] c_BAR_LAST = c_BPX_W'(BAR_WIDTH - 1);

    logic               r_hs_prev;
    logic               r_vs_prev;
    logic [10:0]        r_hcnt;
    logic [9:0]         r_vcnt;
    logic [7:0]         r_frame;
    logic [1:0]         r_mode;
    logic               r_hs_seen;
    logic               r_vs_seen;
    logic               r_locked;
    logic [c_BPX_W-1:0] r_bar_px;
    logic [2:0]         r_bar;

    logic               w_hs_rise;
    logic               w_vs_rise;
    logic [10:0]        w_hcnt_nxt;
    logic               w_active;
    logic [10:0]        w_x;
    logic [10:0]        w_y;
    logic [10:0]        w_sum_r;
    logic [10:0]        w_sum_b;
    logic [11:0]        w_rgb;
    logic               w_unused_ok;

    assign w_hs_rise  = ~r_hs_prev & i_hsync;
    assign w_vs_rise  = ~r_vs_prev & i_vsync;
    assign w_hcnt_nxt = w_hs_rise ? 11'd0 :
                        (r_hcnt == 11'h7FF) ? r_hcnt : r_hcnt + 11'd1;

    // Stage 1: sync sampling, position counters, frame count and mode capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_prev <= 1'b1;
            r_vs_prev <= 1'b1;
            r_hcnt    <= '0;
            r_vcnt    <= '0;
            r_frame   <= '0;
            r_mode    <= '0;
            r_hs_seen <= 1'b0;
            r_vs_seen <= 1'b0;
            r_locked  <= 1'b0;
            r_bar_px  <= '0;
            r_bar     <= '0;
        end else if (i_pix_ce) begin
            r_hs_prev <= i_hsync;
            r_vs_prev <= i_vsync;
            r_hcnt    <= w_hcnt_nxt;
            if (w_vs_rise)
                r_vcnt <= '0;
            else if (w_hs_rise && (r_vcnt != 10'h3FF))
                r_vcnt <= r_vcnt + 10'd1;
            if (w_vs_rise) begin
                r_frame <= r_frame + 8'd1;
                r_mode  <= i_mode;
            end
            r_hs_seen <= r_hs_seen | w_hs_rise;
            r_vs_seen <= r_vs_seen | w_vs_rise;
            r_locked  <= r_locked | ((r_hs_seen | w_hs_rise) & (r_vs_seen | w_vs_rise));
            // Bar index tracks the x of the hcnt value being loaded
            if (w_hcnt_nxt == c_H_START) begin
                r_bar_px <= '0;
                r_bar    <= '0;
            end else if (r_bar_px == c_BAR_LAST) begin
                r_bar_px <= '0;
                r_bar    <= r_bar + 3'd1;
            end else begin
                r_bar_px <= r_bar_px + 1'b1;
            end
        end
    end

    assign w_active = r_locked &&
                      (r_hcnt >= c_H_START) && (r_hcnt < c_H_END) &&
                      (r_vcnt >= c_V_START) && (r_vcnt < c_V_END);
    assign w_x      = r_hcnt - c_H_START;
    assign w_y      = {1'b0, r_vcnt - c_V_START};
    assign w_sum_r  = w_x + {3'b000, r_frame};
    assign w_sum_b  = w_x + w_y;

    assign w_unused_ok = ^{w_sum_r[10:8], w_sum_r[3:0], w_sum_b[10:9], w_sum_b[4:0]};

    always_comb begin
        w_rgb = 12'h000;
        if (w_active) begin
            case (r_mode)
                2'd0:    w_rgb = {{4{~r_bar[1]}}, {4{~r_bar[2]}}, {4{~r_bar[0]}}};
                2'd1:    w_rgb = (w_x[5] ^ w_y[5]) ? 12'hFFF : 12'h000;
                2'd2:    w_rgb = {w_sum_r[7:4], w_y[7:4], w_sum_b[8:5]};
                default: w_rgb = i_solid_rgb;
            endcase
        end
    end

    // Stage 2: registered pin drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_hsync <= 1'b1;
            o_vsync <= 1'b1;
            o_red   <= '0;
            o_green <= '0;
            o_blue  <= '0;
            o_de    <= 1'b0;
        end else if (i_pix_ce) begin
            o_hsync <= r_hs_prev;
            o_vsync <= r_vs_prev;
            o_red   <= w_rgb[11:8];
            o_green <= w_rgb[7:4];
            o_blue  <= w_rgb[3:0];
            o_de    <= w_active;
        end
    end

    assign o_locked = r_locked;

endmodule
`default_nettype wire
